// File: rtl/gene_pkg.sv
// Shared definitions for the gene alignment datapath: problem geometry,
// base encoding, sequencer states and the saturating start-offset helper.
package gene_pkg;

    localparam int P_LEN     = 1024;
    localparam int P_PE      = 64;
    localparam int P_STRIPES = P_LEN / P_PE;
    localparam int P_SCORE_W = 14;

    localparam int A_W     = 10;  // A-memory address width
    localparam int K_W     = 4;   // stripe index width
    localparam int START_W = 11;  // running start offset, holds 0..P_LEN

    typedef logic [1:0] base_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_B = 3'd1,
        GAP    = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4,
        DONE   = 3'd5
    } seq_state_e;

    localparam logic [START_W-1:0] START_CAP     = START_W'(P_LEN);
    localparam logic [START_W:0]   START_CAP_EXT = (START_W + 1)'(P_LEN);

    // Advance the running start offset; it pins at P_LEN instead of wrapping
    // so that every later stripe is recognised as fully consumed.
    function automatic logic [START_W-1:0] sat_start_add(
        input logic [START_W-1:0] cur,
        input logic [A_W-1:0]     inc
    );
        logic [START_W:0] sum;
        sum = {1'b0, cur} + {2'b00, inc};
        if (sum > START_CAP_EXT) begin
            return START_CAP;
        end else begin
            return sum[START_W-1:0];
        end
    endfunction

endpackage

// File: rtl/stripe_result_reg.sv
// Per-stripe result capture: registers the stripe index, the absolute end
// position and the max score, and raises a one-cycle valid pulse.
module stripe_result_reg
    import gene_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic [K_W-1:0]       stripe,
    input  logic [A_W-1:0]       end_position,
    input  logic [START_W-1:0]   start_reg,
    input  logic [P_SCORE_W-1:0] max_score,
    output logic                 res_valid,
    output logic [K_W-1:0]       res_stripe,
    output logic [START_W-1:0]   res_end,
    output logic [P_SCORE_W-1:0] res_max
);

    logic [START_W-1:0] end_sum_s;

    // Absolute end position; 1023 + 1024 still fits in 11 bits, so no overflow.
    always_comb begin
        end_sum_s = {1'b0, end_position} + start_reg;
    end

    // Capture the result fields and pulse valid for exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_stripe <= '0;
            res_end    <= '0;
            res_max    <= '0;
        end else begin
            res_valid <= capture;
            if (capture) begin
                res_stripe <= stripe;
                res_end    <= end_sum_s;
                res_max    <= max_score;
            end
        end
    end

endmodule

// File: rtl/stripe_sequencer.sv
// Stripe sequencer for PE_array_64: loads each stripe's B word, streams
// sequence A from the running start offset, collects the stripe result and
// carries the offset into the next stripe until all 16 stripes are done.
module stripe_sequencer
    import gene_pkg::*;
#(
    parameter int P_TIMEOUT = 2048
)
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_run,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_err,
    output logic [A_W-1:0]       o_a_addr,
    input  logic [1:0]           i_a_data,
    output logic [K_W-1:0]       o_b_addr,
    input  logic [2*P_PE-1:0]    i_b_data,
    output logic [2*P_PE-1:0]    o_B,
    output logic [1:0]           o_A,
    output logic                 o_start,
    input  logic                 i_stripe_end,
    input  logic [A_W-1:0]       i_start_position,
    input  logic [A_W-1:0]       i_end_position,
    input  logic [P_SCORE_W-1:0] i_max_score,
    output logic                 o_res_valid,
    output logic [K_W-1:0]       o_res_stripe,
    output logic [START_W-1:0]   o_res_end,
    output logic [P_SCORE_W-1:0] o_res_max
);

    localparam int DRAIN_W = $clog2(P_TIMEOUT);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(P_TIMEOUT - 1);
    localparam logic [K_W-1:0]     LAST_K     = K_W'(P_STRIPES - 1);

    seq_state_e         state_r;
    logic [K_W-1:0]     k_r;
    logic [START_W-1:0] start_reg_r;
    logic               load_cnt_r;    // 0: address cycle, 1: data cycle of LOAD_B
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic               capture_s;
    base_t              a_base_s;

    // Stripe end is only honoured while the array is working on a stripe.
    always_comb begin
        capture_s = 1'b0;
        case (state_r)
            STREAM:  capture_s = i_stripe_end;
            DRAIN:   capture_s = i_stripe_end;
            default: capture_s = 1'b0;
        endcase
    end

    // A-valid and A base are a direct decode of the registered state, so the
    // memory's one-cycle read latency lines up with the STREAM cycles.
    always_comb begin
        a_base_s = i_a_data;
        if (state_r == STREAM) begin
            o_start = 1'b1;
            o_A     = a_base_s;
        end else begin
            o_start = 1'b0;
            o_A     = 2'b00;
        end
    end

    // Main sequencing FSM with registered control outputs and addresses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            k_r         <= '0;
            start_reg_r <= '0;
            load_cnt_r  <= 1'b0;
            drain_cnt_r <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            o_a_addr    <= '0;
            o_b_addr    <= '0;
            o_B         <= '0;
        end else begin
            o_done <= 1'b0;
            if (capture_s) begin
                start_reg_r <= sat_start_add(start_reg_r, i_start_position);
                if (k_r == LAST_K) begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b1;
                    state_r <= DONE;
                end else begin
                    k_r        <= k_r + 4'd1;
                    o_b_addr   <= k_r + 4'd1;
                    load_cnt_r <= 1'b0;
                    state_r    <= LOAD_B;
                end
            end else begin
                case (state_r)
                    IDLE: begin
                        if (i_run) begin
                            k_r         <= '0;
                            start_reg_r <= '0;
                            o_err       <= 1'b0;
                            o_busy      <= 1'b1;
                            o_b_addr    <= '0;
                            load_cnt_r  <= 1'b0;
                            state_r     <= LOAD_B;
                        end
                    end
                    LOAD_B: begin
                        if (!load_cnt_r) begin
                            load_cnt_r <= 1'b1;
                        end else begin
                            o_B      <= i_b_data;
                            // Prefetch the first A base so it arrives with STREAM.
                            o_a_addr <= start_reg_r[A_W-1:0];
                            state_r  <= GAP;
                        end
                    end
                    GAP: begin
                        o_a_addr    <= o_a_addr + 10'd1;
                        drain_cnt_r <= '0;
                        if (start_reg_r >= START_CAP) begin
                            state_r <= DRAIN;
                        end else begin
                            state_r <= STREAM;
                        end
                    end
                    STREAM: begin
                        o_a_addr <= o_a_addr + 10'd1;
                        // The address runs one ahead of the presented base, so
                        // it reads zero exactly when base P_LEN-1 is presented.
                        if (o_a_addr == 10'd0) begin
                            state_r <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (drain_cnt_r == DRAIN_LAST) begin
                            o_err   <= 1'b1;
                            o_busy  <= 1'b0;
                            o_done  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            drain_cnt_r <= drain_cnt_r + 1'b1;
                        end
                    end
                    DONE: begin
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    stripe_result_reg u_result (
        .clk          (i_clk),
        .rst          (i_rst),
        .capture      (capture_s),
        .stripe       (k_r),
        .end_position (i_end_position),
        .start_reg    (start_reg_r),
        .max_score    (i_max_score),
        .res_valid    (o_res_valid),
        .res_stripe   (o_res_stripe),
        .res_end      (o_res_end),
        .res_max      (o_res_max)
    );

endmodule

// File: tb/tb_stripe_sequencer.sv
// Scoreboard bench for stripe_sequencer: the stimulus process plays the PE
// array, pushing each stripe's expected result; a monitor pops and compares.
module tb_stripe_sequencer;

    logic         clk;
    logic         i_rst;
    logic         i_run;
    logic         o_busy;
    logic         o_done;
    logic         o_err;
    logic [9:0]   o_a_addr;
    logic [1:0]   i_a_data;
    logic [3:0]   o_b_addr;
    logic [127:0] i_b_data;
    logic [127:0] o_B;
    logic [1:0]   o_A;
    logic         o_start;
    logic         i_stripe_end;
    logic [9:0]   i_start_position;
    logic [9:0]   i_end_position;
    logic [13:0]  i_max_score;
    logic         o_res_valid;
    logic [3:0]   o_res_stripe;
    logic [10:0]  o_res_end;
    logic [13:0]  o_res_max;

    stripe_sequencer dut (
        .i_clk            (clk),
        .i_rst            (i_rst),
        .i_run            (i_run),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_a_addr         (o_a_addr),
        .i_a_data         (i_a_data),
        .o_b_addr         (o_b_addr),
        .i_b_data         (i_b_data),
        .o_B              (o_B),
        .o_A              (o_A),
        .o_start          (o_start),
        .i_stripe_end     (i_stripe_end),
        .i_start_position (i_start_position),
        .i_end_position   (i_end_position),
        .i_max_score      (i_max_score),
        .o_res_valid      (o_res_valid),
        .o_res_stripe     (o_res_stripe),
        .o_res_end        (o_res_end),
        .o_res_max        (o_res_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int stripe;
        int res_end;
        int max;
        int len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   res_cnt = 0;
    int   done_cnt = 0;
    int   cnt = 0;
    int   rises = 0;
    int   a_bad = 0;
    int   cur_start = 0;
    int   start_model = 0;
    int   d0 = 0;
    int   r0 = 0;
    bit   prev_start = 1'b0;

    function automatic logic [1:0] a_base(input int addr);
        int v;
        v = addr ^ (addr >> 3) ^ (addr >> 6);
        return v[1:0];
    endfunction

    function automatic logic [127:0] b_word(input int k);
        logic [127:0] w;
        for (int j = 0; j < 8; j++) begin
            w[16*j +: 16] = 16'(k * 4951 + j * 257 + 2575);
        end
        return w;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Synchronous-read gene memories.
    always @(posedge clk) begin
        i_a_data <= a_base(int'(o_a_addr));
        i_b_data <= b_word(int'(o_b_addr));
    end

    // Monitor: pops the scoreboard on every result pulse and checks the
    // A stream (count, contiguity, content) seen since the previous result.
    always @(negedge clk) begin
        exp_t e;
        if (o_res_valid) begin
            res_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL res_unexpected actual_stripe=%0d required=none", o_res_stripe);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("res_stripe_%0d", e.stripe), int'(o_res_stripe), e.stripe);
                chk($sformatf("res_end_%0d", e.stripe), int'(o_res_end), e.res_end);
                chk($sformatf("res_max_%0d", e.stripe), int'(o_res_max), e.max);
                chk($sformatf("start_len_%0d", e.stripe), cnt, e.len);
                chk($sformatf("start_runs_%0d", e.stripe), rises, (e.len > 0) ? 1 : 0);
                chk($sformatf("a_data_bad_%0d", e.stripe), a_bad, 0);
                chk_b($sformatf("b_word_%0d", e.stripe), o_B, b_word(e.stripe));
            end
            cnt = 0;
            rises = 0;
            a_bad = 0;
        end
        if (o_start) begin
            if (!prev_start) rises++;
            if (o_A !== a_base(cur_start + cnt)) a_bad++;
            cnt++;
        end
        prev_start = o_start;
        if (o_done) done_cnt++;
        if (i_rst || o_done) begin
            cnt = 0;
            rises = 0;
            a_bad = 0;
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk_b({name, "_b"}, o_B, 128'd0);
        chk_b({name, "_ctl"},
              {78'd0, o_busy, o_done, o_err, o_start, o_res_valid, o_A,
               o_a_addr, o_b_addr, o_res_stripe, o_res_end, o_res_max},
              128'd0);
    endtask

    task automatic do_run();
        @(posedge clk);
        #1 i_run = 1'b1;
        @(posedge clk);
        #1 i_run = 1'b0;
        chk("busy_after_run", int'(o_busy), 1);
        chk("err_cleared_by_run", int'(o_err), 0);
        start_model = 0;
        d0 = done_cnt;
        r0 = res_cnt;
    endtask

    // Entered in the first LOAD_B cycle of stripe s; ends in the next one.
    // early=1: end on the n-th STREAM cycle; early=0: end on DRAIN cycle n (0-based).
    task automatic do_stripe(input int s, input bit early, input int n,
                             input int sp, input int ep, input int mx, input bit last);
        int   len;
        int   off;
        exp_t e;
        cur_start = start_model;
        if (early) len = n;
        else len = (start_model >= 1024) ? 0 : 1024 - start_model;
        off = early ? 2 + n : 3 + len + n;
        repeat (off) @(posedge clk);
        #1;
        i_stripe_end     = 1'b1;
        i_start_position = 10'(sp);
        i_end_position   = 10'(ep);
        i_max_score      = 14'(mx);
        e.stripe  = s;
        e.res_end = ep + start_model;
        e.max     = mx;
        e.len     = len;
        exp_q.push_back(e);
        start_model = (start_model + sp > 1024) ? 1024 : start_model + sp;
        @(posedge clk);
        #1 i_stripe_end = 1'b0;
        chk($sformatf("res_timing_%0d", s), int'(o_res_valid), 1);
        if (last) begin
            chk("done_pulse", int'(o_done), 1);
            chk("busy_drop", int'(o_busy), 0);
            chk("err_at_done", int'(o_err), 0);
        end
    endtask

    task automatic finish_run(input string name, input int results);
        @(posedge clk);
        #1;
        chk({name, "_done_count"}, done_cnt - d0, 1);
        chk({name, "_result_count"}, res_cnt - r0, results);
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        i_rst = 1'b1;
        i_run = 1'b0;
        i_stripe_end = 1'b0;
        i_start_position = '0;
        i_end_position = '0;
        i_max_score = '0;
        repeat (3) @(posedge clk);
        #1 i_rst = 1'b0;
        chk_reset_outputs("reset_state");

        // Full sweep: 1024 bases per stripe, end 5 cycles into DRAIN.
        do_run();
        for (int s = 0; s < 16; s++) do_stripe(s, 1'b0, 4, 0, s * 37 + 5, 1000 + s * 13, s == 15);
        finish_run("sweep", 16);

        // Offset carry: +64 per stripe, stripe 3 streams 832 from 192, end 1092.
        do_run();
        for (int s = 0; s < 16; s++) do_stripe(s, 1'b0, 2, 64, 900, s + 100, s == 15);
        finish_run("offset", 16);

        // Saturation: 1023 then 100; stripe 1 streams one base, then none.
        do_run();
        do_stripe(0, 1'b0, 0, 1023, 0, 16383, 1'b0);
        for (int s = 1; s < 16; s++) do_stripe(s, 1'b0, 0, 100, 1023, s, s == 15);
        finish_run("saturate", 16);

        // Early end on the 10th STREAM cycle of every stripe.
        do_run();
        for (int s = 0; s < 16; s++) do_stripe(s, 1'b1, 10, 0, s, s, s == 15);
        finish_run("early", 16);

        // Timeout: stripe 4 never ends; err rises after exactly 2048 DRAIN cycles.
        do_run();
        for (int s = 0; s < 4; s++) do_stripe(s, 1'b1, 3, 0, s + 7, s + 50, 1'b0);
        cur_start = start_model;
        repeat (3 + 1024 + 2047) @(posedge clk);
        #1;
        chk("err_before_timeout", int'(o_err), 0);
        chk("done_before_timeout", int'(o_done), 0);
        @(posedge clk);
        #1;
        chk("err_at_timeout", int'(o_err), 1);
        chk("done_at_timeout", int'(o_done), 1);
        chk("busy_at_timeout", int'(o_busy), 0);
        finish_run("timeout", 4);
        chk("err_sticky", int'(o_err), 1);

        // Reset in the middle of stripe 7's STREAM, then a clean rerun.
        do_run();
        for (int s = 0; s < 7; s++) do_stripe(s, 1'b1, 5, 0, s, s, 1'b0);
        cur_start = start_model;
        repeat (3 + 4) @(posedge clk);
        #1;
        chk("stream_before_reset", int'(o_start), 1);
        i_rst = 1'b1;
        @(posedge clk);
        #1 i_rst = 1'b0;
        chk_reset_outputs("mid_reset");
        repeat (5) @(posedge clk);
        #1;
        chk("reset_result_count", res_cnt - r0, 7);
        chk("reset_no_done", done_cnt - d0, 0);
        chk("reset_queue_empty", exp_q.size(), 0);
        do_run();
        for (int s = 0; s < 16; s++) do_stripe(s, 1'b1, 4, 0, s * 3 + 1, 200 - s, s == 15);
        finish_run("rerun", 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stripe_sequencer.md
# stripe_sequencer

Hardware driver for `PE_array_64`: owns the sequence memories' read ports and walks all 16 stripes of a 1024×1024 alignment. It streams one base of sequence A per cycle into the array and carries the running start position across stripes. It collects each stripe's end position and max score. It replaces the software stripe loop used in simulation and sits between the gene memories and the PE array.

## Interface
- `P_LEN`, 1024: bases per sequence (A and B).
- `P_PE`, 64: PE count; `P_STRIPES = P_LEN/P_PE` = 16.
- `P_SCORE_W`, 14: max-score width.
- `P_TIMEOUT`, 2048: cycles allowed in DRAIN before error.
- Ports:
  - `i_clk` in 1: clock.
  - `i_rst` in 1: reset. One clock; reset is synchronous and active-high.
  - `i_run` in 1: start pulse; ignored while `o_busy`=1.
  - `o_busy` out 1: high from the cycle after accepted `i_run` until DONE.
  - `o_done` out 1: one-cycle pulse on entering DONE.
  - `o_err` out 1: sticky timeout flag; cleared by the next accepted `i_run`.
  - `o_a_addr` out 10: A-memory address. Synchronous read, data valid 1 cycle later.
  - `i_a_data` in 2: A-memory data.
  - `o_b_addr` out 4: B-memory word address (stripe k).
  - `i_b_data` in 128: 64 bases; base i at `[2i+:2]`. 1-cycle latency.
  - `o_B` out 128: registered B word to the array.
  - `o_A` out 2: A base to the array.
  - `o_start` out 1: A-valid to the array.
  - `i_stripe_end` in 1: stripe finished.
  - `i_start_position` in 10: offset increment for the next stripe.
  - `i_end_position` in 10: end position relative to the stripe start.
  - `i_max_score` in `P_SCORE_W`: stripe max.
  - `o_res_valid` out 1: one-cycle result pulse.
  - `o_res_stripe` out 4: stripe index.
  - `o_res_end` out 11: `i_end_position + start_reg`, 11-bit unsigned.
  - `o_res_max` out `P_SCORE_W`: captured max score.

## Operation
- Reset values:
  - State IDLE.
  - `o_busy`, `o_done`, `o_err`, `o_start`, `o_res_valid` = 0.
  - `o_A` = 0, `o_B` = 0, addresses = 0.
  - `o_res_*` = 0.
  - Stripe counter k = 0, `start_reg` = 0.
- IDLE: on `i_run`, clear k, `start_reg` and `o_err`, then go to LOAD_B.
- LOAD_B (2 cycles):
  - Cycle 1: drive `o_b_addr`=k.
  - Cycle 2: latch `i_b_data` into `o_B`, then go to GAP.
- GAP (1 cycle):
  - `o_start`=0.
  - Drive `o_a_addr`=`start_reg` (prefetch).
  - If `start_reg` ≥ `P_LEN`, go to DRAIN; otherwise go to STREAM.
- STREAM:
  - `o_start`=1 and `o_A`=`i_a_data` (combinational gate by state).
  - `o_a_addr` increments each cycle.
  - The cycle that presents base `P_LEN`-1 is the last; then go to DRAIN.
- DRAIN: `o_start`=0, `o_A`=0; wait for `i_stripe_end`.
- `i_stripe_end` is sampled only in STREAM and DRAIN; it is ignored in other states. When sampled high in either state (early end allowed):
  - Capture `o_res_end` = {0,`i_end_position`} + `start_reg`.
  - Capture `o_res_max` and `o_res_stripe`=k.
  - Pulse `o_res_valid` next cycle.
  - `start_reg` ← `start_reg` + `i_start_position`. `start_reg` is 11 bits and saturates at 1024; it never wraps.
  - If k = 15, go to DONE; otherwise k++ and go to LOAD_B.
- Timeout: after `P_TIMEOUT` consecutive cycles in DRAIN, set `o_err`=1 and go to DONE. No `o_res_valid` is issued for that stripe.
- DONE: pulse `o_done`, drop `o_busy`, return to IDLE.

## Timing
- Accepted `i_run` at cycle t:
  - LOAD_B at t+1..t+2; `o_B` is valid from t+3.
  - GAP at t+3; first `o_start`=1 at t+4 with `o_A`=A[`start_reg`].
- `o_start` is contiguous: it stays high for exactly `P_LEN`−`start_reg` cycles, unless an early `i_stripe_end` ends STREAM.
- `o_B` is stable from GAP until the next LOAD_B completes.
- `i_stripe_end` at cycle c gives `o_res_valid` at c+1 and next-stripe LOAD_B at c+1.
- Minimum gap between stripes is 3 cycles of `o_start`=0 (LOAD_B×2 + GAP).
- `i_rst` mid-stripe: IDLE at the next edge.
  - `o_start` = 0 after that edge.
  - No `o_res_valid` and no `o_done` are emitted.

## Structure
- Shared package `gene_pkg`:
  - `P_LEN`, `P_PE`, `P_STRIPES`, `P_SCORE_W`.
  - Base encoding typedef `base_t` (2 bits).
  - State enum `seq_state_e` {IDLE, LOAD_B, GAP, STREAM, DRAIN, DONE}.
- Sub-module `stripe_result_reg`: captures and pulses the result fields, and computes the 11-bit end sum.

## Test plan
- Full sweep, model array ends each stripe 5 cycles into DRAIN with `i_start_position`=0:
  - 16 `o_res_valid` pulses, each preceded by 1024 contiguous `o_start` cycles.
  - `o_done` once; `o_err`=0.
- Offset carry, `i_start_position`=64 per stripe and `i_end_position`=900:
  - Stripe 3 streams from address 192 for 832 cycles.
  - `o_res_end`=1092 for stripe 3.
- Saturation, `i_start_position`=1023 on stripe 0 then 100:
  - `start_reg` saturates at 1024.
  - Stripe 2 onward has zero `o_start` cycles; results are still reported.
- Early end, `i_stripe_end` at the 10th STREAM cycle of stripe 0:
  - `o_start` falls at the next cycle.
  - `o_res_stripe`=0; stripe 1 LOAD_B follows.
- Timeout, array never asserts `i_stripe_end` on stripe 4:
  - `o_err`=1 after 2048 DRAIN cycles.
  - `o_done` pulses; only 4 results are issued.
- Reset mid-STREAM of stripe 7, then `i_run`:
  - Outputs return to reset values.
  - Rerun starts at stripe 0 with `start_reg`=0.
